// File: rtl/cr_kme_word_packer.sv
// cr_kme_word_packer
// Packs 32-bit upstream beats into 64-bit words for the downstream kme fifo.
// The first beat of a pair goes in bits [31:0] and the second in bits [63:32].
// A beat flagged in_last that arrives with no low half held is zero-padded
// into a word of its own.
// One completed word is parked in a pending register. The fifo write and a
// new word landing in that register can happen in the same cycle.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready : upstream beat handshake
//   fifo_in         : pending packed word (write data)
//   fifo_in_valid   : write strobe, combinational from pend_v and stall
//   fifo_in_stall   : downstream full / stall override
//   word_cnt/pad_cnt: statistics; constant 0 unless CR_KME_PACKER_STATS_EN
//
// Build option: define CR_KME_PACKER_STATS_EN to compile in the counters.

module cr_kme_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] fifo_in,
  output logic        fifo_in_valid,
  input  logic        fifo_in_stall,
  output logic [15:0] word_cnt,
  output logic [15:0] pad_cnt
);

  localparam int unsigned LANE_W = 32;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } lane_state_e;

  lane_state_e       state_q, state_d;
  logic [LANE_W-1:0] lo_reg, lo_d;
  logic [WORD_W-1:0] pend_data, pend_data_d;
  logic              pend_v, pend_v_d;
  logic              accept;
  logic              drain;

  // Accept only when the pending slot is free or is being written this cycle.
  assign in_ready      = ~rst & (~pend_v | ~fifo_in_stall);
  assign fifo_in_valid = ~rst & pend_v & ~fifo_in_stall;
  assign fifo_in       = pend_data;
  assign accept        = in_valid & in_ready;
  assign drain         = fifo_in_valid;

  // Lane FSM next state and datapath next values.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_reg;
    pend_data_d = pend_data;
    pend_v_d    = pend_v & ~drain;
    if (accept) begin
      unique case (state_q)
        EMPTY: begin
          if (in_last) begin
            pend_data_d = {LANE_W'(0), in_data};
            pend_v_d    = 1'b1;
          end else begin
            lo_d    = in_data;
            state_d = HALF;
          end
        end
        HALF: begin
          pend_data_d = {in_data, lo_reg};
          pend_v_d    = 1'b1;
          state_d     = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      lo_reg    <= '0;
      pend_data <= '0;
      pend_v    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_reg    <= lo_d;
      pend_data <= pend_data_d;
      pend_v    <= pend_v_d;
    end
  end

`ifdef CR_KME_PACKER_STATS_EN
  logic             pend_pad;
  logic [CNT_W-1:0] word_q;
  logic [CNT_W-1:0] pad_q;

  // pend_pad marks the parked word as a zero-padded single-beat word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_pad <= 1'b0;
      word_q   <= '0;
      pad_q    <= '0;
    end else begin
      if (accept && (state_q == HALF || in_last)) begin
        pend_pad <= (state_q == EMPTY);
      end
      if (drain) begin
        word_q <= word_q + CNT_W'(1);
      end
      if (drain && pend_pad) begin
        pad_q <= pad_q + CNT_W'(1);
      end
    end
  end

  assign word_cnt = word_q;
  assign pad_cnt  = pad_q;
`else
  assign word_cnt = '0;
  assign pad_cnt  = '0;
`endif

endmodule

// File: tb/tb_cr_kme_word_packer.sv
// Bench for cr_kme_word_packer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected words and counts.

module tb_cr_kme_word_packer;

`ifdef CR_KME_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] fifo_in;
  logic        fifo_in_valid;
  logic        fifo_in_stall = 1'b0;
  logic [15:0] word_cnt;
  logic [15:0] pad_cnt;

  cr_kme_word_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .fifo_in      (fifo_in),
    .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall),
    .word_cnt     (word_cnt),
    .pad_cnt      (pad_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: held low half and the parked word {pad flag, word}.
  logic [31:0] m_half[$];
  logic [64:0] m_pend[$];
  logic [15:0] m_words = '0;
  logic [15:0] m_pads  = '0;

  // Observed writes and the cycle each happened in.
  logic [63:0] wr_log[$];
  int          wr_cyc[$];

  function automatic bit m_ready();
    return !rst && (m_pend.size() == 0 || !fifo_in_stall);
  endfunction

  function automatic bit m_write();
    return !rst && m_pend.size() != 0 && !fifo_in_stall;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("fifo_in_valid", 64'(fifo_in_valid), 64'(m_write()));
    if (m_pend.size() != 0) chk("fifo_in", fifo_in, m_pend[0][63:0]);
    chk("word_cnt", 64'(word_cnt), 64'(STATS ? m_words : 16'h0));
    chk("pad_cnt", 64'(pad_cnt), 64'(STATS ? m_pads : 16'h0));
    if (fifo_in_valid) begin
      wr_log.push_back(fifo_in);
      wr_cyc.push_back(cycle);
    end
  end

  // Model update at the active edge from the inputs presented that cycle.
  always @(posedge clk) begin
    bit wr;
    bit acc;
    cycle++;
    if (rst) begin
      m_half.delete();
      m_pend.delete();
      m_words = '0;
      m_pads  = '0;
    end else begin
      wr  = m_write();
      acc = in_valid && m_ready();
      if (wr) begin
        m_words = m_words + 16'd1;
        if (m_pend[0][64]) m_pads = m_pads + 16'd1;
        void'(m_pend.pop_front());
      end
      if (acc) begin
        if (m_half.size() == 0) begin
          if (in_last) m_pend.push_back({1'b1, 32'h0, in_data});
          else         m_half.push_back(in_data);
        end else begin
          m_pend.push_back({1'b0, in_data, m_half.pop_front()});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("reset_fifo_in", fifo_in, 64'h0);
    chk("reset_word_cnt", 64'(word_cnt), 64'h0);

    // Two beats back to back form one word.
    n0 = wr_log.size();
    drive(32'h1111_1111, 1'b0);
    drive(32'h2222_2222, 1'b0);
    chk("pair_valid", 64'(fifo_in_valid), 64'h1);
    chk("pair_word", fifo_in, 64'h2222_2222_1111_1111);
    idle(2);
    chk("pair_count", 64'(wr_log.size()), 64'(n0 + 1));

    // Single last beat from EMPTY is zero-padded.
    drive(32'hDEAD_BEEF, 1'b1);
    chk("pad_valid", 64'(fifo_in_valid), 64'h1);
    chk("pad_word", fifo_in, 64'h0000_0000_DEAD_BEEF);
    idle(2);
    chk("pad_cnt_lit", 64'(pad_cnt), STATS ? 64'h1 : 64'h0);
    chk("word_cnt_lit", 64'(word_cnt), STATS ? 64'h2 : 64'h0);

    // Stall with a parked word: nothing accepted or written for 10 cycles.
    fifo_in_stall = 1'b1;
    drive(32'h0000_0003, 1'b0);
    drive(32'h0000_0004, 1'b0);
    n0 = wr_log.size();
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    repeat (10) begin
      step();
      chk("stall_ready", 64'(in_ready), 64'h0);
      chk("stall_valid", 64'(fifo_in_valid), 64'h0);
    end
    chk("stall_nowrite", 64'(wr_log.size()), 64'(n0));
    fifo_in_stall = 1'b0;
    step();
    in_data = 32'h0000_0006;
    step();
    idle(3);
    chk("release_count", 64'(wr_log.size()), 64'(n0 + 2));
    chk("release_word0", wr_log[n0], 64'h0000_0004_0000_0003);
    chk("release_word1", wr_log[n0 + 1], 64'h0000_0006_0000_0005);

    // Stream 8 beats: 4 writes two cycles apart.
    do_reset();
    n0 = wr_log.size();
    for (int i = 0; i < 8; i++) drive(32'h10 + 32'(i), 1'b0);
    idle(3);
    chk("stream_count", 64'(wr_log.size()), 64'(n0 + 4));
    for (int k = 1; k < 4; k++)
      chk("stream_spacing", 64'(wr_cyc[n0 + k] - wr_cyc[n0 + k - 1]), 64'h2);
    chk("stream_word0", wr_log[n0], 64'h0000_0011_0000_0010);
    chk("stream_word3", wr_log[n0 + 3], 64'h0000_0017_0000_0016);
    chk("stream_word_cnt", 64'(word_cnt), STATS ? 64'h4 : 64'h0);

    // Reset with a stalled parked word, then reset while HALF.
    fifo_in_stall = 1'b1;
    drive(32'h0000_0030, 1'b1);
    n0 = wr_log.size();
    do_reset();
    fifo_in_stall = 1'b0;
    drive(32'h0000_0040, 1'b0);
    do_reset();
    idle(3);
    chk("rst_nowrite", 64'(wr_log.size()), 64'(n0));
    drive(32'h0000_000A, 1'b0);
    drive(32'h0000_000B, 1'b0);
    idle(2);
    chk("rst_after_count", 64'(wr_log.size()), 64'(n0 + 1));
    chk("rst_after_word", wr_log[n0], 64'h0000_000B_0000_000A);

`ifdef CR_KME_PACKER_STATS_EN
    // 65537 padded writes wrap the counters to 1.
    do_reset();
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(3);
    chk("wrap_word_cnt", 64'(word_cnt), 64'h1);
    chk("wrap_pad_cnt", 64'(pad_cnt), 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_kme_word_packer.md
CR_KME_WORD_PACKER -- requirements
Module: cr_kme_word_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_data, input, 32 bits: upstream beat payload.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data/in_last valid.
REQ-005 SHALL have port in_last, input, 1 bit: final beat of a record; forces flush of a partial word.
REQ-006 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid & in_ready.
REQ-007 SHALL have port fifo_in, output, 64 bits: packed word to the downstream kme fifo write data.
REQ-008 SHALL have port fifo_in_valid, output, 1 bit: single-cycle write strobe to the downstream fifo.
REQ-009 SHALL have port fifo_in_stall, input, 1 bit: downstream fifo full or stall-override; no write permitted while high.
REQ-010 SHALL have port word_cnt, output, 16 bits: words written (stats, see Configuration).
REQ-011 SHALL have port pad_cnt, output, 16 bits: zero-padded words written (stats).

Function
REQ-012 SHALL hold a lane FSM with states EMPTY (no low half held) and HALF (low half held in lo_reg[31:0]).
REQ-013 SHALL hold a pending-word register pend_data[63:0] with flag pend_v; fifo_in SHALL equal pend_data at all times.
REQ-014 SHALL drive fifo_in_valid = pend_v & ~fifo_in_stall, combinationally; a write drains pend_v in the same cycle.
REQ-015 SHALL drive in_ready = ~pend_v | ~fifo_in_stall, so a beat is never accepted into a word that cannot be parked.
REQ-016 EMPTY + accepted beat, in_last=0: lo_reg <= in_data; go HALF; pend unchanged.
REQ-017 EMPTY + accepted beat, in_last=1: pend_data <= {32'h0, in_data}; pend_v <= 1; stay EMPTY; word counts as padded.
REQ-018 HALF + accepted beat (any in_last): pend_data <= {in_data, lo_reg}; pend_v <= 1; go EMPTY.
REQ-019 Lane order fixed: first beat -> bits [31:0], second beat -> bits [63:32].
REQ-020 Simultaneous drain and reload (fifo_in_valid=1 and a word-completing beat in the same cycle): pend_v SHALL remain 1 with new data; no word lost or duplicated.
REQ-021 pend_v=1 and fifo_in_stall=1: in_ready=0; lo_reg, FSM and pend_data SHALL hold unchanged.
REQ-022 HALF with no further beat: lo_reg held indefinitely; no timeout flush.
REQ-023 Throughput: with fifo_in_stall=0 and continuous in_valid, one 64-bit write every 2 cycles, no bubbles.
REQ-024 Latency: word-completing beat accepted at cycle N -> fifo_in_valid at cycle N+1 if fifo_in_stall=0.

Reset
REQ-025 On rst=1 at a clock edge: FSM <= EMPTY, pend_v <= 0, pend_data <= 0, lo_reg <= 0, word_cnt <= 0, pad_cnt <= 0.
REQ-026 Reset mid-record SHALL discard any held half and pending word; nothing written to the fifo in the reset cycle or the cycle after.
REQ-027 While rst=1, fifo_in_valid SHALL be 0 and in_ready SHALL be 0.

Configuration
REQ-028 Macro CR_KME_PACKER_STATS_EN SHALL compile in the statistics counters.
REQ-029 Defined: word_cnt increments on each fifo_in_valid; pad_cnt increments on each fifo_in_valid whose word was created per REQ-017; both wrap 16'hFFFF -> 0.
REQ-030 Undefined: word_cnt and pad_cnt ports SHALL exist and be driven constant 0; no counter flops.

Verification
REQ-031 Beats 32'h1111_1111, 32'h2222_2222 back-to-back, stall=0 -> one write fifo_in=64'h2222_2222_1111_1111 one cycle after second beat.
REQ-032 Single beat 32'hDEAD_BEEF with in_last=1 from EMPTY -> write 64'h0000_0000_DEAD_BEEF; pad_cnt=1 (stats on).
REQ-033 Hold fifo_in_stall=1 with pending word for 10 cycles, keep in_valid=1 -> in_ready=0 throughout, no write; release -> exactly one write, then streaming resumes.
REQ-034 Stream 8 beats, stall=0 -> 4 writes at 2-cycle spacing, word_cnt=4 (stats on) / 0 (stats off).
REQ-035 Assert rst while HALF with pend_v=1 -> after reset no write occurs; next two beats 32'hA, 32'hB yield 64'h0000_000B_0000_000A.
REQ-036 Drive 65537 writes (stats on) -> word_cnt=1.
